wb_master_cmd: RTL and testbench
================================

Name: wb_master_cmd

Overview:
- Wishbone B4 classic single-transfer master that sits directly upstream of the register-array slave.
- Accepts one read or write command at a time on a valid/ready command port.
- Runs one CYC/STB bus phase, waits for ACK, ERR or a timeout, and returns the result on a valid/ready response port.
- Turns CPU-side or test-harness-side requests into bus cycles for the slave.

Parameters:
ADDR_WIDTH, 16, width of cmd_adr_i and adr_o
DATA_WIDTH, 32, data width (8/16/32/64)
GRANULE, 8, select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam)
TIMEOUT_CYCLES, 64, bus cycles allowed before abort; 0 disables the timeout

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_we_i  in  1  1 = write, 0 = read
cmd_adr_i  in  ADDR_WIDTH  register address
cmd_dat_i  in  DATA_WIDTH  write data
cmd_sel_i  in  SEL_WIDTH  byte/granule selects
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i
rsp_dat_o  out  DATA_WIDTH  read data; 0 for writes, errors and timeouts
rsp_err_o  out  1  slave signalled ERR
rsp_timeout_o  out  1  no ACK/ERR within TIMEOUT_CYCLES
cyc_o, stb_o, we_o  out  1 each  Wishbone cycle, strobe, write enable
adr_o  out  ADDR_WIDTH  Wishbone address
dat_o  out  DATA_WIDTH  Wishbone write data
sel_o  out  SEL_WIDTH  Wishbone selects
dat_i  in  DATA_WIDTH  Wishbone read data
ack_i, err_i  in  1 each  Wishbone termination

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0.
  - adr_o, dat_o, sel_o, rsp_dat_o = 0.
  - State IDLE; timeout counter = 0.
- Bus outputs are registered. cmd_ready_o is combinational: state==IDLE && !ack_i && !err_i. This guard lets a registered slave release a stale ACK/ERR before the next strobe.
- States:
  - IDLE:
    - On cmd accept, latch we/adr/dat/sel into we_o/adr_o/dat_o/sel_o.
    - Assert cyc_o=stb_o=1 next cycle, clear counter, go to BUS.
    - For reads, dat_o is still loaded from cmd_dat_i (don't-care to the slave).
  - BUS:
    - cyc_o=stb_o=1 and address/data/sel held stable.
    - Each cycle, evaluate in priority order err_i > ack_i > timeout:
    - err_i=1: drop cyc_o/stb_o, rsp_err_o=1, rsp_dat_o=0, go to RESP.
    - ack_i=1: drop cyc_o/stb_o. rsp_dat_o = dat_i for reads, 0 for writes. Go to RESP.
    - Otherwise counter++. If TIMEOUT_CYCLES≠0 and counter reaches TIMEOUT_CYCLES-1, drop cyc_o/stb_o, rsp_timeout_o=1, rsp_dat_o=0, go to RESP.
  - RESP:
    - rsp_valid_o=1; response fields held stable until rsp_ready_i.
    - On handshake: rsp_valid_o=0, clear rsp_err_o and rsp_timeout_o, go to IDLE.
- Gap rules:
  - Minimum gap between stb_o deassertion and the next assertion is 2 cycles (RESP, then IDLE).
  - The gap is longer while ack_i or err_i stays high.
- Latency: command accept to stb_o high = 1 cycle. ACK sampled to rsp_valid_o high = 1 cycle.
- Simultaneous ack_i and err_i: treated as error.
- ack_i or err_i outside BUS: ignored (they only hold off cmd_ready_o).
- Timeout semantics: with TIMEOUT_CYCLES=N, stb_o is high for exactly N cycles before abort, unless terminated earlier.
- Counter: $clog2(TIMEOUT_CYCLES+1) bits; saturates and never wraps.
- Reset mid-operation (BUS or RESP): cyc_o/stb_o low on the next cycle, pending response discarded, return to IDLE.
- Only one outstanding transaction. No pipelining, no burst, no RMW-locked cycles.

Test Plan:
- Write then read: write adr=0x3, dat=0xDEADBEEF, sel=0xF, slave acks after 2 cycles → one rsp with err=0, timeout=0, dat=0. Read adr=0x3 → rsp_dat_o=0xDEADBEEF, exactly one stb_o phase per command.
- Partial select: write 0x11223344 with sel=0xF, then write 0xAABBCCDD with sel=0x5, read back → 0x11BB33DD.
- Error: read adr=0x20 to a slave asserting err_i → rsp_err_o=1, rsp_dat_o=0; cmd_ready_o stays low until err_i falls.
- Timeout: TIMEOUT_CYCLES=4, silent slave → stb_o high exactly 4 cycles, then rsp_timeout_o=1. Next command is accepted normally.
- Backpressure: hold rsp_ready_i=0 for 10 cycles after ACK → rsp fields stable, cmd_ready_o=0, stb_o=0 throughout. Release → handshake in 1 cycle.
- Reset mid-BUS: assert rst_i during stb_o → next cycle all outputs at reset values, no rsp_valid_o. A following write completes normally.

Source files
------------

// File: rtl/wb_master_cmd_if.sv
// Command/response handshake plus Wishbone B4 classic bus bundle for wb_master_cmd.
// The master modport is the controller's view; the slave modport is the far side.
interface wb_master_cmd_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0]  cmd_sel_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;
  logic                  err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_master_cmd.sv
// Single-transfer Wishbone B4 classic master: one command in, one bus phase, one response out.
// Terminations are prioritised err > ack > timeout; all bus and response outputs are registered.
module wb_master_cmd #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int GRANULE        = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_master_cmd_if.master bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  // Width floor of 1 keeps the counter legal when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cyc_q;
  logic                  stb_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic                  rsp_err_q;
  logic                  rsp_to_q;
  logic                  cmd_ready;

  // Holding off while ack/err is still high lets a registered slave drop a stale termination.
  assign cmd_ready = (state_q == S_IDLE) && !bus.ack_i && !bus.err_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid_i && cmd_ready) begin
            we_q    <= bus.cmd_we_i;
            adr_q   <= bus.cmd_adr_i;
            dat_q   <= bus.cmd_dat_i;
            sel_q   <= bus.cmd_sel_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_BUS;
          end
        end
        S_BUS: begin
          if (bus.err_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (bus.ack_i) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : bus.dat_i;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            // Comparing the pre-increment count gives exactly TIMEOUT_CYCLES strobe cycles.
            if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
              cyc_q       <= 1'b0;
              stb_q       <= 1'b0;
              rsp_to_q    <= 1'b1;
              rsp_dat_q   <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o   = cmd_ready;
  assign bus.cyc_o         = cyc_q;
  assign bus.stb_o         = stb_q;
  assign bus.we_o          = we_q;
  assign bus.adr_o         = adr_q;
  assign bus.dat_o         = dat_q;
  assign bus.sel_o         = sel_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_dat_o     = rsp_dat_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_to_q;
endmodule

// File: tb/tb_wb_master_cmd.sv
// Directed bench for wb_master_cmd against a small register-array slave with ack, err and silent modes.
module tb_wb_master_cmd;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int M_ACK = 0, M_ERR = 1, M_SILENT = 2;

  logic clk;
  logic rst;
  wb_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8)) bus ();

  wb_master_cmd #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave model
  bit [31:0] mem [0:63];
  int        mode      = M_ACK;
  int        ack_delay = 2;
  bit        err_hold  = 1'b0;
  int        wcnt;
  logic      ack_r, err_r;

  assign bus.ack_i = ack_r;
  assign bus.err_i = err_r;
  assign bus.dat_i = mem[bus.adr_o[5:0]];

  always @(posedge clk) begin
    if (rst) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      wcnt  <= 0;
    end else begin
      ack_r <= 1'b0;
      err_r <= (mode == M_ERR) && err_hold && (err_r || (bus.cyc_o && bus.stb_o));
      if (mode == M_ACK && bus.cyc_o && bus.stb_o && !ack_r) begin
        if (wcnt == ack_delay - 1) begin
          ack_r <= 1'b1;
          wcnt  <= 0;
          if (bus.we_o)
            for (int i = 0; i < 4; i++)
              if (bus.sel_o[i]) mem[bus.adr_o[5:0]][8*i +: 8] <= bus.dat_o[8*i +: 8];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // Strobe monitor
  int   stb_cycles = 0;
  int   stb_phases = 0;
  logic stb_prev   = 1'b0;
  always @(posedge clk) begin
    if (bus.stb_o) stb_cycles <= stb_cycles + 1;
    if (bus.stb_o && !stb_prev) stb_phases <= stb_phases + 1;
    stb_prev <= bus.stb_o;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_cmd(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("cmd_accept_wait", ok, 1);
    if (ok) @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rsp_valid_wait", ok, 1);
  endtask

  task automatic get_rsp(output logic [31:0] rdat, output logic rerr, output logic rto);
    bit ok;
    wait_rsp(ok);
    rdat = bus.rsp_dat_o;
    rerr = bus.rsp_err_o;
    rto  = bus.rsp_timeout_o;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", bus.rsp_valid_o, 0);
  endtask

  logic [31:0] rdat;
  logic        rerr, rto;
  int          p0, c0;
  bit          ok;

  initial begin
    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", bus.cyc_o, 0);
    check("rst_stb", bus.stb_o, 0);
    check("rst_we", bus.we_o, 0);
    check("rst_adr", bus.adr_o, 0);
    check("rst_dat", bus.dat_o, 0);
    check("rst_sel", bus.sel_o, 0);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_err", bus.rsp_err_o, 0);
    check("rst_rsp_to", bus.rsp_timeout_o, 0);
    check("rst_rsp_dat", bus.rsp_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.cmd_ready_o, 1);

    // Write then read
    p0 = stb_phases;
    send_cmd(1'b1, 16'h3, 32'hDEADBEEF, 4'hF);
    check("wr_stb_latency", bus.stb_o, 1);
    check("wr_cyc", bus.cyc_o, 1);
    check("wr_we", bus.we_o, 1);
    check("wr_adr", bus.adr_o, 16'h3);
    check("wr_dat", bus.dat_o, 32'hDEADBEEF);
    check("wr_sel", bus.sel_o, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("wr_rsp_dat", rdat, 0);
    check("wr_rsp_err", rerr, 0);
    check("wr_rsp_to", rto, 0);
    check("wr_phases", stb_phases - p0, 1);
    p0 = stb_phases;
    send_cmd(1'b0, 16'h3, 32'h0, 4'hF);
    check("rd_we", bus.we_o, 0);
    get_rsp(rdat, rerr, rto);
    check("rd_rsp_dat", rdat, 32'hDEADBEEF);
    check("rd_rsp_err", rerr, 0);
    check("rd_phases", stb_phases - p0, 1);

    // Partial select
    send_cmd(1'b1, 16'h5, 32'h11223344, 4'hF);
    get_rsp(rdat, rerr, rto);
    send_cmd(1'b1, 16'h5, 32'hAABBCCDD, 4'h5);
    get_rsp(rdat, rerr, rto);
    check("pw_rsp_dat_zero", rdat, 0);
    send_cmd(1'b0, 16'h5, 32'h0, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("partial_rd", rdat, 32'h11BB33DD);

    // Error: slave holds data at 0x20 but responds with err
    send_cmd(1'b1, 16'h20, 32'hCAFEF00D, 4'hF);
    get_rsp(rdat, rerr, rto);
    mode     = M_ERR;
    err_hold = 1'b1;
    send_cmd(1'b0, 16'h20, 32'h0, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("err_rsp_err", rerr, 1);
    check("err_rsp_dat", rdat, 0);
    check("err_rsp_to", rto, 0);
    check("err_ready_held", bus.cmd_ready_o, 0);
    @(negedge clk);
    check("err_ready_held2", bus.cmd_ready_o, 0);
    err_hold = 1'b0;
    @(negedge clk);
    check("err_released", bus.err_i, 0);
    check("err_ready_back", bus.cmd_ready_o, 1);
    mode = M_ACK;

    // Timeout with silent slave
    mode = M_SILENT;
    c0 = stb_cycles;
    send_cmd(1'b0, 16'h7, 32'h0, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("to_rsp_to", rto, 1);
    check("to_rsp_err", rerr, 0);
    check("to_rsp_dat", rdat, 0);
    check("to_stb_cycles", stb_cycles - c0, TO);
    mode = M_ACK;
    send_cmd(1'b1, 16'h8, 32'h55AA55AA, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("post_to_err", rerr, 0);
    check("post_to_to", rto, 0);

    // Backpressure
    send_cmd(1'b0, 16'h3, 32'h0, 4'hF);
    wait_rsp(ok);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", bus.rsp_valid_o, 1);
      check("bp_dat", bus.rsp_dat_o, 32'hDEADBEEF);
      check("bp_ready", bus.cmd_ready_o, 0);
      check("bp_stb", bus.stb_o, 0);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    check("bp_hs_valid", bus.rsp_valid_o, 0);
    check("bp_hs_ready", bus.cmd_ready_o, 1);

    // Reset mid-BUS
    mode = M_SILENT;
    send_cmd(1'b0, 16'h9, 32'h0, 4'hF);
    check("mid_stb_high", bus.stb_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_cyc", bus.cyc_o, 0);
    check("mid_stb", bus.stb_o, 0);
    check("mid_adr", bus.adr_o, 0);
    check("mid_rsp_valid", bus.rsp_valid_o, 0);
    check("mid_rsp_to", bus.rsp_timeout_o, 0);
    repeat (6) @(negedge clk);
    check("mid_no_rsp", bus.rsp_valid_o, 0);
    mode = M_ACK;
    send_cmd(1'b1, 16'hA, 32'h12345678, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("mid_wr_err", rerr, 0);
    send_cmd(1'b0, 16'hA, 32'h0, 4'hF);
    get_rsp(rdat, rerr, rto);
    check("mid_rd_dat", rdat, 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
